mips_trace_buffer: RTL and testbench

//  Debug trace capture block that sits beside the mips core and snoops its writeback and store buses.

---
 rtl/mips_trace_pkg.sv | 28 ++
 rtl/mips_trace_buffer_fifo.sv | 61 ++++++
 rtl/mips_trace_buffer.sv | 148 ++++++++++++++
 tb/tb_mips_trace_buffer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_trace_pkg.sv
// Shared types for the mips trace capture block: FSM states, entry kinds
// and the packed trace record stored in the buffer.
package mips_trace_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        FROZEN  = 2'd3
    } trace_state_t;

    localparam logic KIND_REG = 1'b0;
    localparam logic KIND_MEM = 1'b1;

    // The stamp field is sized for the widest supported stamp counter;
    // narrower counters are zero-extended into it.
    localparam int unsigned STAMP_MAX_W = 32;
    localparam int unsigned IDX_W       = 18;
    localparam int unsigned DATA_W      = 32;

    typedef struct packed {
        logic                   kind;
        logic [STAMP_MAX_W-1:0] stamp;
        logic [IDX_W-1:0]       idx;
        logic [DATA_W-1:0]      data;
    } trace_entry_t;

endpackage

// File: rtl/mips_trace_buffer_fifo.sv
// trace_fifo: DEPTH-entry first-word-fall-through buffer of trace records.
// Flush has priority over push/pop; the head is forced to zero when empty.
module trace_fifo
    import mips_trace_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic                    push,
    input  logic                    pop,
    input  trace_entry_t            din,
    output trace_entry_t            head,
    output logic                    valid,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    trace_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign valid   = (count != '0);
    assign do_pop  = pop && valid && !flush;
    assign do_push = push && !flush && ((count != FULL_COUNT) || do_pop);
    assign head    = valid ? mem[rd_ptr] : '0;

    // Storage array: written at the tail on an accepted push.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mips_trace_buffer.sv
// mips_trace_buffer: arm/trigger controlled capture of core register writes
// (and, with macro TRACE_MEMWR_EN defined, memory stores) into a stamped
// FWFT trace buffer drained by a valid/pop handshake.
module mips_trace_buffer
    import mips_trace_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned STAMP_W = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    arm,
    input  logic [31:0]             trig_pc,
    input  logic [31:0]             pc,
    input  logic                    regWrite,
    input  logic [4:0]              write_reg,
    input  logic [31:0]             write_data,
    input  logic                    memWrite,
    input  logic [17:0]             mem_addr,
    input  logic [31:0]             mem_wdata,
    input  logic                    pop,
    output logic                    entry_valid,
    output logic                    entry_kind,
    output logic [STAMP_W-1:0]      entry_stamp,
    output logic [17:0]             entry_idx,
    output logic [31:0]             entry_data,
    output logic [1:0]              state,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(DEPTH - 1);

    trace_state_t       cur_state;
    trace_state_t       next_state;
    logic [STAMP_W-1:0] stamp;
    logic               hit;
    logic               reg_ev;
    logic               mem_ev;
    logic               cap_en;
    logic               push;
    logic               drop;
    logic               fill;
    trace_entry_t       push_entry;
    trace_entry_t       head;
    logic               fifo_valid;

    assign hit    = (pc == trig_pc);
    assign reg_ev = regWrite && (write_reg != '0);

`ifdef TRACE_MEMWR_EN
    assign mem_ev = memWrite;
`else
    logic [50:0] unused_mem;
    assign mem_ev     = 1'b0;
    assign unused_mem = {memWrite, mem_addr, mem_wdata};
`endif

    // Event qualification and record assembly; a register write wins over a
    // simultaneous store, which is then counted as dropped.
    always_comb begin
        cap_en     = !arm && ((cur_state == CAPTURE) || ((cur_state == ARMED) && hit));
        push       = cap_en && (reg_ev || mem_ev);
        drop       = !arm && (((cur_state == FROZEN) && (reg_ev || mem_ev)) ||
                              (cap_en && reg_ev && mem_ev));
        fill       = push && !(pop && fifo_valid) && (count == LAST_SLOT);
        push_entry = '0;
        push_entry.stamp = STAMP_MAX_W'(stamp);
        if (reg_ev) begin
            push_entry.kind = KIND_REG;
            push_entry.idx  = {13'b0, write_reg};
            push_entry.data = write_data;
        end
`ifdef TRACE_MEMWR_EN
        else begin
            push_entry.kind = KIND_MEM;
            push_entry.idx  = mem_addr;
            push_entry.data = mem_wdata;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) cur_state <= IDLE;
        else       cur_state <= next_state;
    end

    // FSM next state: arm overrides everything; filling the buffer freezes capture.
    always_comb begin
        next_state = cur_state;
        if (arm) begin
            next_state = ARMED;
        end else begin
            case (cur_state)
                ARMED:   if (hit)  next_state = fill ? FROZEN : CAPTURE;
                CAPTURE: if (fill) next_state = FROZEN;
                default: next_state = cur_state;
            endcase
        end
    end

    // Cycle stamp: zeroed by arm, counts from the trigger cycle onwards, wraps silently.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)       stamp <= '0;
        else if (arm)    stamp <= '0;
        else if (cap_en) stamp <= stamp + 1'b1;
    end

    // Sticky overflow: set on any dropped event, cleared only by arm or reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)     overflow <= 1'b0;
        else if (arm)  overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (arm),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .head  (head),
        .valid (fifo_valid),
        .count (count)
    );

    logic [STAMP_MAX_W-1:0] unused_head_stamp;
    assign unused_head_stamp = head.stamp;

    assign state       = cur_state;
    assign entry_valid = fifo_valid;
    assign entry_stamp = head.stamp[STAMP_W-1:0];
    assign entry_idx   = head.idx;
    assign entry_data  = head.data;
`ifdef TRACE_MEMWR_EN
    assign entry_kind  = head.kind;
`else
    logic unused_kind;
    assign unused_kind = head.kind;
    assign entry_kind  = 1'b0;
`endif

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Self-checking bench for mips_trace_buffer: a queue-based reference model
// predicts every entry and status output, plus a table of register-write
// vectors and hand-written multi-cycle sequences.
module tb_mips_trace_buffer;
    import mips_trace_pkg::*;

    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        arm = 1'b0;
    logic [31:0] trig_pc = 32'h0000_0400;
    logic [31:0] pc = '0;
    logic        regWrite = 1'b0;
    logic [4:0]  write_reg = '0;
    logic [31:0] write_data = '0;
    logic        memWrite = 1'b0;
    logic [17:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        pop = 1'b0;
    logic        entry_valid;
    logic        entry_kind;
    logic [15:0] entry_stamp;
    logic [17:0] entry_idx;
    logic [31:0] entry_data;
    logic [1:0]  state;
    logic [4:0]  count;
    logic        overflow;

    mips_trace_buffer #(
        .DEPTH   (DEPTH),
        .STAMP_W (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .arm         (arm),
        .trig_pc     (trig_pc),
        .pc          (pc),
        .regWrite    (regWrite),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .memWrite    (memWrite),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .pop         (pop),
        .entry_valid (entry_valid),
        .entry_kind  (entry_kind),
        .entry_stamp (entry_stamp),
        .entry_idx   (entry_idx),
        .entry_data  (entry_data),
        .state       (state),
        .count       (count),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

`ifdef TRACE_MEMWR_EN
    localparam bit MEM_EN = 1'b1;
`else
    localparam bit MEM_EN = 1'b0;
`endif

    typedef struct {
        logic        kind;
        logic [15:0] stamp;
        logic [17:0] idx;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        string       name;
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        int          exp_count;
    } vec_t;

    exp_t         sb[$];
    trace_state_t m_state;
    logic [15:0]  m_stamp;
    logic         m_ovf;
    int           n_tests = 0;
    int           n_fail = 0;
    vec_t         vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_state = IDLE;
        m_stamp = '0;
        m_ovf   = 1'b0;
    endtask

    // Predict the effect of the current inputs at the coming rising edge.
    task automatic model_edge();
        logic ev_reg, ev_mem, cap, popped;
        exp_t e;
        if (arm) begin
            sb.delete();
            m_state = ARMED;
            m_stamp = '0;
            m_ovf   = 1'b0;
            return;
        end
        ev_reg = regWrite && (write_reg != 5'd0);
        ev_mem = MEM_EN && memWrite;
        cap    = (m_state == CAPTURE) || ((m_state == ARMED) && (pc == trig_pc));
        popped = pop && (sb.size() > 0);
        if (popped) void'(sb.pop_front());
        if (m_state == FROZEN) begin
            if (ev_reg || ev_mem) m_ovf = 1'b1;
        end else if (cap) begin
            if (ev_reg) begin
                e = '{kind: 1'b0, stamp: m_stamp, idx: {13'b0, write_reg}, data: write_data};
                sb.push_back(e);
            end else if (ev_mem) begin
                e = '{kind: 1'b1, stamp: m_stamp, idx: mem_addr, data: mem_wdata};
                sb.push_back(e);
            end
            if (ev_reg && ev_mem) m_ovf = 1'b1;
            m_stamp = m_stamp + 16'd1;
            m_state = (sb.size() == DEPTH) ? FROZEN : CAPTURE;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, count, sb.size());
        chk({tag, ".valid"}, entry_valid, sb.size() != 0);
        chk({tag, ".state"}, state, m_state);
        chk({tag, ".overflow"}, overflow, m_ovf);
        if (sb.size() != 0) begin
            chk({tag, ".kind"},  entry_kind,  sb[0].kind);
            chk({tag, ".stamp"}, entry_stamp, sb[0].stamp);
            chk({tag, ".idx"},   entry_idx,   sb[0].idx);
            chk({tag, ".data"},  entry_data,  sb[0].data);
        end else begin
            chk({tag, ".zero_entry"}, {entry_kind, entry_stamp, entry_idx, entry_data}, 64'd0);
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    task automatic quiet();
        arm = 1'b0; regWrite = 1'b0; memWrite = 1'b0; pop = 1'b0;
    endtask

    initial begin
        vecs[0] = '{name: "reg0_ignored",  rw: 1'b1, wr: 5'd0,  wd: 32'hDEAD_BEEF, exp_count: 1};
        vecs[1] = '{name: "reg7_push",     rw: 1'b1, wr: 5'd7,  wd: 32'hA5A5_0001, exp_count: 2};
        vecs[2] = '{name: "no_strobe",     rw: 1'b0, wr: 5'd9,  wd: 32'h0000_0001, exp_count: 2};
        vecs[3] = '{name: "reg31_push",    rw: 1'b1, wr: 5'd31, wd: 32'hFFFF_FFFF, exp_count: 3};
        vecs[4] = '{name: "reg0_again",    rw: 1'b1, wr: 5'd0,  wd: 32'h0000_0000, exp_count: 3};

        model_reset();
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check_all("reset");
        chk("reset_state_idle", state, 2'd0);

        // Pop on an empty buffer in IDLE.
        pop = 1'b1;
        step("idle_empty_pop");
        chk("idle_empty_pop_count", count, 5'd0);
        quiet();

        // Arm, then trigger with a write to $5.
        arm = 1'b1;
        step("arm1");
        chk("arm1_state", state, 2'd1);
        quiet();
        pc = 32'h0000_0400; regWrite = 1'b1; write_reg = 5'd5; write_data = 32'h0000_1234;
        step("trigger");
        chk("trigger_valid", entry_valid, 1'b1);
        chk("trigger_idx",   entry_idx,   18'd5);
        chk("trigger_stamp", entry_stamp, 16'd0);
        chk("trigger_data",  entry_data,  32'h0000_1234);
        chk("trigger_state", state, 2'd2);
        pc = 32'h0000_0404;
        quiet();

        // Table-driven register writes during capture.
        for (int i = 0; i < 5; i++) begin
            regWrite = vecs[i].rw; write_reg = vecs[i].wr; write_data = vecs[i].wd;
            step(vecs[i].name);
            chk({vecs[i].name, ".tbl_count"}, count, vecs[i].exp_count);
        end
        quiet();

        // Push and pop together at count 3.
        regWrite = 1'b1; write_reg = 5'd8; write_data = 32'h0000_0088; pop = 1'b1;
        step("push_pop");
        chk("push_pop_count", count, 5'd3);
        chk("push_pop_head",  entry_idx, 18'd7);
        quiet();
        pop = 1'b1;
        repeat (3) step("drain1");
        chk("drain1_valid", entry_valid, 1'b0);
        quiet();

        // Overfill: 17 writes starting on the trigger cycle.
        pc = 32'h0; arm = 1'b1;
        step("arm2");
        quiet();
        pc = 32'h0000_0400;
        for (int i = 0; i < 17; i++) begin
            regWrite = 1'b1; write_reg = 5'(i + 1); write_data = 32'h100 + 32'(i);
            step("fill17");
        end
        quiet();
        chk("fill17_count", count, 5'd16);
        chk("fill17_state", state, 2'd3);
        chk("fill17_ovf",   overflow, 1'b1);
        pop = 1'b1; regWrite = 1'b1; write_reg = 5'd3;
        repeat (3) step("frozen_pop");
        chk("frozen_pop_state", state, 2'd3);
        quiet();

        // Arm with pop while frozen.
        pc = 32'h0; arm = 1'b1; pop = 1'b1;
        step("arm_frozen");
        chk("arm_frozen_state", state, 2'd1);
        chk("arm_frozen_count", count, 5'd0);
        chk("arm_frozen_ovf",   overflow, 1'b0);
        quiet();

        // Exactly DEPTH writes: full and frozen without overflow, then drain.
        pc = 32'h0000_0400;
        for (int i = 0; i < DEPTH; i++) begin
            regWrite = 1'b1; write_reg = 5'd20; write_data = 32'(i) * 32'h11;
            step("fill16");
        end
        quiet();
        chk("fill16_state", state, 2'd3);
        chk("fill16_ovf",   overflow, 1'b0);
        pop = 1'b1;
        repeat (DEPTH + 1) step("drain16");
        chk("drain16_valid", entry_valid, 1'b0);
        chk("drain16_count", count, 5'd0);
        quiet();

`ifdef TRACE_MEMWR_EN
        pc = 32'h0; arm = 1'b1;
        step("arm_mem");
        quiet();
        pc = 32'h0000_0400; memWrite = 1'b1; mem_addr = 18'h0003C; mem_wdata = 32'hFFFF_FFFF;
        step("store");
        chk("store_kind", entry_kind, 1'b1);
        chk("store_idx",  entry_idx,  18'h0003C);
        regWrite = 1'b1; write_reg = 5'd2; write_data = 32'h22;
        step("reg_and_store");
        chk("reg_and_store_ovf", overflow, 1'b1);
        quiet();
`endif

        // Asynchronous reset in the middle of a capture.
        pc = 32'h0; arm = 1'b1;
        step("arm_rst");
        quiet();
        pc = 32'h0000_0400; regWrite = 1'b1; write_reg = 5'd4; write_data = 32'h44;
        repeat (3) step("pre_rst");
        quiet();
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("async_rst_count", count, 5'd0);
        check_all("async_rst");
        #1 reset = 1'b0;
        step("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
